// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: issues sequential reads to a 1-cycle instruction
// memory and buffers the returned {pc, instruction} pairs in a 2-entry FIFO for decode.
module instruction_fetch_unit #(
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter logic [INSTRUCTION_WIDTH-1:0] RESET_PC          = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] redirect_target,
    output logic                         imem_en,
    output logic [INSTRUCTION_WIDTH-1:0] imem_address,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
    output logic                         if_valid,
    output logic [INSTRUCTION_WIDTH-1:0] if_instruction,
    output logic [INSTRUCTION_WIDTH-1:0] if_pc
);
    localparam int W = INSTRUCTION_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, REDIRECT} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [1:0]     count_q, count_d;
    logic           inflight_q, inflight_d;
    logic [W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [W-1:0]   fifo_pc_q [2];
    logic [W-1:0]   fifo_pc_d [2];
    logic [W-1:0]   fifo_instr_q [2];
    logic [W-1:0]   fifo_instr_d [2];

    logic           pop;
    logic           issue;
    logic           take_redirect;
    logic [1:0]     occupancy;
    logic [1:0]     wr_slot;

    // Occupancy counts the response already in flight, so at most two entries are ever owed.
    always_comb begin
        if_valid      = (count_q != 2'd0);
        pop           = if_valid & ~stall & ~redirect_valid;
        occupancy     = count_q + {1'b0, inflight_q} - {1'b0, pop};
        issue         = (state_q == RUN) & ~redirect_valid & (occupancy <= 2'd1);
        take_redirect = redirect_valid & (state_q != IDLE);
        wr_slot       = count_q - {1'b0, pop};

        imem_en        = issue;
        imem_address   = pc_q;
        if_pc          = if_valid ? fifo_pc_q[0]    : '0;
        if_instruction = if_valid ? fifo_instr_q[0] : '0;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        count_d       = count_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;

        if (take_redirect) begin
            state_d    = REDIRECT;
            count_d    = 2'd0;
            inflight_d = 1'b0;
            pc_d       = redirect_target & ~W'(3);
        end else begin
            state_d = RUN;
            if (pop) begin
                fifo_pc_d[0]    = fifo_pc_q[1];
                fifo_instr_d[0] = fifo_instr_q[1];
            end
            // Push lands behind whatever survives the pop, keeping program order.
            if (inflight_q) begin
                fifo_pc_d[wr_slot[0]]    = inflight_pc_q;
                fifo_instr_d[wr_slot[0]] = imem_instruction;
            end
            count_d    = occupancy;
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = pc_q;
                pc_d          = pc_q + W'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            count_q       <= 2'd0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                fifo_pc_q[gi]    <= '0;
                fifo_instr_q[gi] <= '0;
            end else begin
                fifo_pc_q[gi]    <= fifo_pc_d[gi];
                fifo_instr_q[gi] <= fifo_instr_d[gi];
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based fetch model checked every cycle,
// plus hand-computed expectations for reset, stall, redirect, wrap and mid-stream reset.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;

    logic        imem_en, imem_en2;
    logic [31:0] imem_address, imem_address2;
    logic [31:0] imem_instruction = 32'h0;
    logic [31:0] imem_instruction2 = 32'h0;
    logic        if_valid, if_valid2;
    logic [31:0] if_instruction, if_instruction2;
    logic [31:0] if_pc, if_pc2;

    logic [31:0] mem_xor = 32'h0;
    bit          check_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_en(imem_en), .imem_address(imem_address), .imem_instruction(imem_instruction),
        .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc)
    );

    instruction_fetch_unit #(.INSTRUCTION_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_en(imem_en2), .imem_address(imem_address2), .imem_instruction(imem_instruction2),
        .if_valid(if_valid2), .if_instruction(if_instruction2), .if_pc(if_pc2)
    );

    always #5 clk = ~clk;

    // Memories answer one cycle after the request; data is the address (dut xor'd with mem_xor).
    always @(posedge clk) begin
        imem_instruction  <= imem_en  ? (imem_address ^ mem_xor) : 32'hDEAD_BEEF;
        imem_instruction2 <= imem_en2 ? imem_address2            : 32'hBAD0_0000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_buf[$];
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;
    logic [31:0] m_pc = 32'h0;
    int          m_hold = 1;
    bit          m_booting = 1'b1;

    function automatic bit m_pop();
        return (m_buf.size() != 0) && !stall && !redirect_valid;
    endfunction

    function automatic bit m_fetch();
        return (m_hold == 0) && !redirect_valid &&
               (m_buf.size() + int'(m_pend) - int'(m_pop()) <= 1);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_buf.delete();
                m_pend    = 1'b0;
                m_pc      = 32'h0;
                m_hold    = 1;
                m_booting = 1'b1;
            end else begin
                bit p, f;
                p = m_pop();
                f = m_fetch();
                if (redirect_valid && !m_booting) begin
                    m_buf.delete();
                    m_pend = 1'b0;
                    m_pc   = redirect_target & ~32'h3;
                    m_hold = 1;
                end else begin
                    if (p) void'(m_buf.pop_front());
                    if (m_pend) m_buf.push_back('{m_pend_pc, m_pend_pc ^ mem_xor});
                    m_pend    = f;
                    m_pend_pc = m_pc;
                    if (f) m_pc = m_pc + 32'd4;
                    m_hold    = 0;
                    m_booting = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            bit v;
            v = (m_buf.size() != 0);
            chk("m_imem_en",      32'(imem_en),   32'(m_fetch()));
            chk("m_imem_address", imem_address,   m_pc);
            chk("m_if_valid",     32'(if_valid),  32'(v));
            chk("m_if_pc",        if_pc,          v ? m_buf[0].pc : 32'h0);
            chk("m_if_instr",     if_instruction, v ? m_buf[0].instr : 32'h0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input bit s, input bit r, input logic [31:0] t);
        @(posedge clk);
        #1;
        stall           = s;
        redirect_valid  = r;
        redirect_target = t;
        @(negedge clk);
    endtask

    logic [63:0] stall_pat = 64'h3C81_0E60_8C07_1A30;
    logic [31:0] tgt_tab [3] = '{32'h0000_1003, 32'hFFFF_FFF6, 32'h0000_0040};

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        check_en = 1'b1;

        // C1: reset released; redirect during IDLE must be ignored
        @(posedge clk); #1;
        rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0500;
        @(negedge clk);
        chk("c1_imem_en", 32'(imem_en), 32'd0);
        chk("c1_if_valid", 32'(if_valid), 32'd0);
        cyc(0, 0, 0);                                   // C2: first issue
        chk("c2_imem_en", 32'(imem_en), 32'd1);
        chk("c2_imem_address", imem_address, 32'h0);
        chk("c2_dut2_address", imem_address2, 32'hFFFF_FFF8);
        cyc(0, 0, 0);                                   // C3
        chk("c3_if_valid", 32'(if_valid), 32'd0);
        chk("c3_imem_address", imem_address, 32'h4);
        cyc(0, 0, 0);                                   // C4
        chk("c4_if_pc", if_pc, 32'h0);
        chk("c4_if_valid", 32'(if_valid), 32'd1);
        chk("c4_dut2_if_pc", if_pc2, 32'hFFFF_FFF8);
        cyc(0, 0, 0);                                   // C5
        chk("c5_if_instr", if_instruction, 32'h4);
        chk("c5_dut2_if_pc", if_pc2, 32'hFFFF_FFFC);
        cyc(1, 0, 0);                                   // C6: stall begins with if_pc=8
        chk("c6_if_pc", if_pc, 32'h8);
        chk("c6_dut2_if_pc", if_pc2, 32'h0);
        chk("c6_dut2_if_instr", if_instruction2, 32'h0);
        for (int i = 7; i <= 10; i++) begin
            cyc(1, 0, 0);
            chk("stall_if_pc", if_pc, 32'h8);
            chk("stall_imem_en", 32'(imem_en), 32'd0);
        end
        cyc(0, 0, 0);                                   // C11: release
        chk("c11_if_pc", if_pc, 32'h8);
        chk("c11_imem_address", imem_address, 32'h10);
        cyc(0, 0, 0);
        chk("c12_if_pc", if_pc, 32'hC);
        cyc(0, 0, 0);
        chk("c13_if_pc", if_pc, 32'h10);

        // redirect with a live head and a response in flight
        cyc(0, 1, 32'h0000_0103);
        chk("ra_imem_en", 32'(imem_en), 32'd0);
        cyc(0, 0, 0);
        chk("ra_bubble_valid", 32'(if_valid), 32'd0);
        chk("ra_bubble_en", 32'(imem_en), 32'd0);
        cyc(0, 0, 0);
        chk("ra_address", imem_address, 32'h100);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("ra_if_pc", if_pc, 32'h100);

        // fill the buffer, then redirect while stalled
        repeat (3) cyc(1, 0, 0);
        chk("rb_full_en", 32'(imem_en), 32'd0);
        cyc(1, 1, 32'h0000_2000);
        chk("rb_head_pc", if_pc, 32'h104);
        cyc(0, 0, 0);
        chk("rb_valid", 32'(if_valid), 32'd0);
        cyc(0, 0, 0);
        chk("rb_address", imem_address, 32'h2000);
        repeat (2) cyc(0, 0, 0);
        chk("rb_if_pc", if_pc, 32'h2000);

        // redirect arriving while already in REDIRECT restarts it
        cyc(0, 1, 32'h0000_0300);
        cyc(0, 1, 32'h0000_0404);
        cyc(0, 0, 0);
        chk("rc_bubble_en", 32'(imem_en), 32'd0);
        cyc(0, 0, 0);
        chk("rc_address", imem_address, 32'h404);
        repeat (2) cyc(0, 0, 0);
        chk("rc_if_pc", if_pc, 32'h404);

        // reset mid-stream with a full buffer
        repeat (3) cyc(1, 0, 0);
        chk("rst_pre_valid", 32'(if_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instruction, 32'h0);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_address", imem_address, 32'h0);
        chk("rst_dut2_address", imem_address2, 32'hFFFF_FFF8);
        stall = 1'b0;
        mem_xor = 32'h00A0_0000;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("r2_c1_en", 32'(imem_en), 32'd0);
        cyc(0, 0, 0);
        chk("r2_c2_address", imem_address, 32'h0);
        repeat (2) cyc(0, 0, 0);
        chk("r2_c4_if_pc", if_pc, 32'h0);
        chk("r2_c4_if_instr", if_instruction, 32'h00A0_0000);

        // mixed stall / redirect traffic, checked by the model
        for (int i = 0; i < 64; i++) begin
            bit r;
            r = ((i % 17) == 9);
            cyc(stall_pat[i], r, tgt_tab[(i / 17) % 3]);
        end
        cyc(0, 0, 0);
        repeat (4) cyc(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
